histogram_engine: RTL

- Parametrised successor to the team's histogram unit.
- Bins streaming samples into a memory of saturating counters with a configurable bin width.
- Adds a BRAM-friendly pipelined read-modify-write path with same-bin forwarding, an independent read-out port, a clear-sweep state machine, a sticky saturation flag and a total-sample counter.
- Sits behind a sample source and in front of a host/readout FSM.

---
 rtl/histogram_pkg.sv | 17 +
 rtl/histogram_if.sv | 31 +++
 rtl/histogram_mem.sv | 37 +++
 rtl/histogram_engine.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/histogram_pkg.sv
// Shared types and helpers for the histogram engine: FSM state encoding and
// a saturating increment usable at any counter width up to 63 bits.
package histogram_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    return (value == max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/histogram_if.sv
// Sample, clear and read-out signals between the histogram engine, its
// sample source and the host-side readout logic.
interface histogram_if #(
  parameter int DATA_W    = 7,
  parameter int BIN_SHIFT = 0,
  parameter int CNT_W     = 5,
  parameter int TOTAL_W   = 16
);
  localparam int BIN_W = DATA_W - BIN_SHIFT;

  logic               ENA;
  logic [DATA_W-1:0]  d_in;
  logic               CLR;
  logic               rd_en;
  logic [BIN_W-1:0]   rd_addr;
  logic [CNT_W-1:0]   rd_data;
  logic               rd_valid;
  logic               busy;
  logic               sat;
  logic [TOTAL_W-1:0] total;

  modport master (
    output ENA, d_in, CLR, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, sat, total
  );

  modport slave (
    input  ENA, d_in, CLR, rd_en, rd_addr,
    output rd_data, rd_valid, busy, sat, total
  );
endinterface

// File: rtl/histogram_mem.sv
// Counter storage: port A reads the bin entering the update pipeline while
// writing the bin leaving it; port B is the read-only host port.
module histogram_mem #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_rd_en,
  input  logic [ADDR_W-1:0] a_rd_addr,
  output logic [DATA_W-1:0] a_rd_data,
  input  logic              a_wr_en,
  input  logic [ADDR_W-1:0] a_wr_addr,
  input  logic [DATA_W-1:0] a_wr_data,
  input  logic              b_rd_en,
  input  logic [ADDR_W-1:0] b_rd_addr,
  output logic [DATA_W-1:0] b_rd_data
);

  // NOTE: the array itself is never reset; the engine zeroes it with its
  // clear sweep, which keeps it mappable onto block RAM.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: non-blocking reads of mem return the pre-write contents when a
  // read and a write hit the same address on the same edge.
  always_ff @(posedge clk) begin
    if (a_wr_en) mem[a_wr_addr] <= a_wr_data;
    if (a_rd_en) a_rd_data <= mem[a_rd_addr];
  end

  // Output register reset is supported by block RAM primitives.
  always_ff @(posedge clk) begin
    if (rst)          b_rd_data <= '0;
    else if (b_rd_en) b_rd_data <= mem[b_rd_addr];
  end

endmodule

// File: rtl/histogram_engine.sv
// Streaming histogram: pipelined read-modify-write of saturating bin counters
// with same-bin forwarding, a clear-sweep FSM and an independent read port.
module histogram_engine
  import histogram_pkg::*;
#(
  parameter int DATA_W    = 7,
  parameter int BIN_SHIFT = 0,
  parameter int CNT_W     = 5,
  parameter int TOTAL_W   = 16
) (
  input logic        CLK,
  input logic        RST,
  histogram_if.slave bus
);

  localparam int BIN_W = DATA_W - BIN_SHIFT;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sweep_q, sweep_d;
  logic               live, accept;

  logic               s1_valid, s2_valid, wb_valid;
  logic [BIN_W-1:0]   s1_bin, s2_bin, wb_bin;
  logic [CNT_W-1:0]   wb_data, ram_q, old_cnt, new_cnt;
  logic               upd_we;

  logic               mem_we;
  logic [BIN_W-1:0]   mem_waddr;
  logic [CNT_W-1:0]   mem_wdata;

  logic               sat_q;
  logic [TOTAL_W-1:0] total_q;
  logic               rd_req_q, rd_valid_q;
  logic [BIN_W-1:0]   rd_addr_q;
  logic [CNT_W-1:0]   rd_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      CLEAR: begin
        if (bus.CLR) begin
          sweep_d = '0;
        end else if (&sweep_q) begin
          state_d = RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + BIN_W'(1);
        end
      end
      RUN: begin
        if (bus.CLR) begin
          state_d = CLEAR;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        sweep_d = '0;
      end
    endcase
  end

  // A clear request kills both new samples and anything still in flight.
  assign live   = (state_q == RUN) && !bus.CLR;
  assign accept = live && bus.ENA;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      wb_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid && live;
      wb_valid <= upd_we;
    end
  end

  always_ff @(posedge CLK) begin
    s1_bin  <= BIN_W'(bus.d_in >> BIN_SHIFT);
    s2_bin  <= s1_bin;
    wb_bin  <= s2_bin;
    wb_data <= new_cnt;
  end

  // The RAM read for S2 was taken on the same edge as the previous write,
  // so a same-bin predecessor's result must be taken from wb_data.
  assign old_cnt = (wb_valid && (wb_bin == s2_bin)) ? wb_data : ram_q;
  assign new_cnt = CNT_W'(sat_inc(64'(old_cnt), CNT_W));
  assign upd_we  = s2_valid && live;

  always_comb begin
    mem_we    = upd_we;
    mem_waddr = s2_bin;
    mem_wdata = new_cnt;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_q;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || bus.CLR) begin
      sat_q   <= 1'b0;
      total_q <= '0;
    end else begin
      if (upd_we && (old_cnt == CNT_MAX)) sat_q <= 1'b1;
      if (accept) total_q <= TOTAL_W'(sat_inc(64'(total_q), TOTAL_W));
    end
  end

  // The RAM access lags the request by one edge so reads see every write
  // committed up to and including the request edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_req_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_req_q   <= bus.rd_en && (state_q == RUN);
      rd_valid_q <= rd_req_q;
    end
  end

  always_ff @(posedge CLK) begin
    rd_addr_q <= bus.rd_addr;
  end

  histogram_mem #(
    .ADDR_W (BIN_W),
    .DATA_W (CNT_W)
  ) u_mem (
    .clk       (CLK),
    .rst       (RST),
    .a_rd_en   (s1_valid),
    .a_rd_addr (s1_bin),
    .a_rd_data (ram_q),
    .a_wr_en   (mem_we),
    .a_wr_addr (mem_waddr),
    .a_wr_data (mem_wdata),
    .b_rd_en   (rd_req_q),
    .b_rd_addr (rd_addr_q),
    .b_rd_data (rd_q)
  );

  assign bus.rd_data  = rd_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state_q == CLEAR);
  assign bus.sat      = sat_q;
  assign bus.total    = total_q;

endmodule
